// File: rtl/m_loadstore_unit.sv
// ============================================================================
// Module   : m_loadstore_unit
// Purpose  : Memory-stage load/store responder. Issues byte/half/word
//            accesses to a word-wide synchronous SRAM with byte enables,
//            stalls the pipeline for the access, returns extended load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_loadstore_unit #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1    // legal range 1..7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_memread,
  input  logic              i_lsu_memwrite,
  input  logic [5:0]        i_lsu_opcode,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  output logic              o_lsu_stall,
  output logic              o_lsu_rvalid,
  output logic [31:0]       o_lsu_rdata,
  output logic              o_lsu_misalign,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [2:0] C_LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Decoded view of the incoming request
  logic        w_is_load, w_is_store, w_use_wr, w_use_rd, w_qual, w_misalign;
  logic [1:0]  w_lane, w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_stall;

  // Captured request
  logic              we_q, uns_q, mis_q;
  logic [1:0]        size_q, lane_q;
  logic [3:0]        be_q;
  logic [ADDR_W-3:0] maddr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [2:0]        cnt_q;

  // Load-result extension
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Opcode decode, qualification, alignment and lane steering of the request
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (i_lsu_opcode)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: w_is_load  = 1'b1;
      6'b101000, 6'b101001, 6'b101011:                       w_is_store = 1'b1;
      default: ;
    endcase
    // A store opcode with memwrite wins; otherwise fall back to the read.
    w_use_wr = i_lsu_memwrite & w_is_store;
    w_use_rd = ~w_use_wr & i_lsu_memread & w_is_load;
    w_qual   = w_use_wr | w_use_rd;

    w_lane = i_lsu_addr[1:0];
    w_size = i_lsu_opcode[1:0];   // 00 byte, 01 half, 11 word
    w_misalign = ((w_size == 2'b01) && w_lane[0]) ||
                 ((w_size == 2'b11) && (w_lane != 2'b00));

    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_lsu_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_lsu_wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and stall decode
  always_comb begin
    state_d = state_q;
    w_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_qual) begin
          w_stall = 1'b1;
          state_d = w_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (i_mem_ready) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (cnt_q == 3'd1) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Select and extend the addressed lane of the returned SRAM word
  always_comb begin
    case (lane_q)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (size_q)
      2'b00:   w_ext = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  // Request capture, read-latency counter and load-result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      be_q    <= 4'b0000;
      maddr_q <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_qual) begin
            we_q    <= w_use_wr;
            uns_q   <= i_lsu_opcode[2];
            mis_q   <= w_misalign;
            size_q  <= w_size;
            lane_q  <= w_lane;
            be_q    <= w_be;
            maddr_q <= i_lsu_addr[ADDR_W-1:2];
            wdata_q <= w_wdata;
            rdata_q <= 32'd0;   // stores and misaligned accesses return zero
          end
        end
        S_REQ: begin
          if (i_mem_ready && !we_q) cnt_q <= C_LAT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) rdata_q <= w_ext;
        end
        default: ;
      endcase
    end
  end

  // The combinational stall path is masked so reset clears it immediately
  // even while upstream still presents a request.
  assign o_lsu_stall    = w_stall & i_rst_n;
  assign o_lsu_rvalid   = (state_q == S_DONE);
  assign o_lsu_misalign = (state_q == S_DONE) & mis_q;
  assign o_lsu_rdata    = rdata_q;
  assign o_mem_req      = (state_q == S_REQ);
  assign o_mem_we       = we_q;
  assign o_mem_be       = be_q;
  assign o_mem_addr     = maddr_q;
  assign o_mem_wdata    = wdata_q;

endmodule

`default_nettype wire
